// File: rtl/mc_control.sv
// Multi-cycle main control FSM for the extended MIPS datapath: Moore-decoded enables and mux selects.
// Optional feature macro JMXOR_EN enables the jmxor (funct 110010) JMXEXEC/JMXWB path.
module mc_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       regwrite,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       immzx,
  output logic       aluop1,
  output logic       aluop0,
  output logic       jmxor,
  output logic [1:0] pcsource,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADDR  = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_RTEXEC   = 4'd6;
  localparam logic [3:0] S_RTWB     = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_ORIEXEC  = 4'd10;
  localparam logic [3:0] S_ORIWB    = 4'd11;
`ifdef JMXOR_EN
  localparam logic [3:0] S_JMXEXEC  = 4'd12;
  localparam logic [3:0] S_JMXWB    = 4'd13;
  localparam logic [5:0] FN_JMXOR   = 6'b110010;
`else
  logic unused_funct;
  assign unused_funct = ^funct;
`endif

  logic [3:0] state_q;
  logic [3:0] next_state;

  assign state = state_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= next_state;
  end

  // Next-state logic; op/funct only matter in DECODE and MEMADDR
  always_comb begin
    next_state = S_FETCH;
    case (state_q)
      S_FETCH:   next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADDR;
          OP_RTYPE: begin
`ifdef JMXOR_EN
            next_state = (funct == FN_JMXOR) ? S_JMXEXEC : S_RTEXEC;
`else
            next_state = S_RTEXEC;
`endif
          end
          OP_BEQ:  next_state = S_BRANCH;
          OP_J:    next_state = S_JUMP;
          OP_ORI:  next_state = S_ORIEXEC;
          default: next_state = S_FETCH;
        endcase
      end
      S_MEMADDR: begin
        if (op == OP_LW)      next_state = S_MEMREAD;
        else if (op == OP_SW) next_state = S_MEMWRITE;
        else                  next_state = S_FETCH;
      end
      S_MEMREAD: next_state = S_MEMWB;
      S_RTEXEC:  next_state = S_RTWB;
      S_ORIEXEC: next_state = S_ORIWB;
`ifdef JMXOR_EN
      S_JMXEXEC: next_state = S_JMXWB;
`endif
      default:   next_state = S_FETCH;
    endcase
  end

  // Moore output decode; reset gates every output so nothing writes while it is held
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    memtoreg    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    immzx       = 1'b0;
    aluop1      = 1'b0;
    aluop0      = 1'b0;
    jmxor       = 1'b0;
    pcsource    = 2'b00;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          memread = 1'b1; irwrite = 1'b1; pcwrite = 1'b1; alusrcb = 2'b01;
        end
        S_DECODE:   alusrcb = 2'b11;
        S_MEMADDR: begin
          alusrca = 1'b1; alusrcb = 2'b10;
        end
        S_MEMREAD: begin
          memread = 1'b1; iord = 1'b1;
        end
        S_MEMWB: begin
          regwrite = 1'b1; memtoreg = 1'b1;
        end
        S_MEMWRITE: begin
          memwrite = 1'b1; iord = 1'b1;
        end
        S_RTEXEC: begin
          alusrca = 1'b1; aluop1 = 1'b1;
        end
        S_RTWB: begin
          regwrite = 1'b1; regdst = 1'b1; aluop1 = 1'b1;
        end
        S_BRANCH: begin
          alusrca = 1'b1; aluop0 = 1'b1; pcwritecond = 1'b1; pcsource = 2'b01;
        end
        S_JUMP: begin
          pcwrite = 1'b1; pcsource = 2'b10;
        end
        S_ORIEXEC: begin
          alusrca = 1'b1; alusrcb = 2'b10; immzx = 1'b1; aluop1 = 1'b1; aluop0 = 1'b1;
        end
        S_ORIWB: begin
          regwrite = 1'b1; immzx = 1'b1; aluop1 = 1'b1; aluop0 = 1'b1;
        end
`ifdef JMXOR_EN
        S_JMXEXEC: begin
          alusrca = 1'b1; aluop1 = 1'b1; jmxor = 1'b1;
        end
        S_JMXWB: begin
          regwrite = 1'b1; regdst = 1'b1; aluop1 = 1'b1; jmxor = 1'b1;
          pcwrite = 1'b1; pcsource = 2'b11;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
